// File: rtl/shift_sequencer.sv
// Run-control sequencer for the 8-bit one-hot right shifter: paces shift_sel at a programmable
// interval, handles run/pause/step/abort, and counts sweeps (one-hot bit reaching the LSB).
module shift_sequencer #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned SWEEP_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_step,
  input  logic [DIV_W-1:0]   i_period,
  input  logic [SWEEP_W-1:0] i_sweeps,
  input  logic [7:0]         i_pos,
  output logic               o_shift_sel,
  output logic               o_shift_rst,
  output logic               o_busy,
  output logic               o_paused,
  output logic               o_done,
  output logic               o_err,
  output logic [SWEEP_W-1:0] o_sweep_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

  state_e               r_state;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     r_period;
  logic [SWEEP_W-1:0]   r_sweeps;
  logic [SWEEP_W-1:0]   r_sweep_cnt;
  logic                 r_shift_sel;
  logic                 r_shift_rst;
  logic                 r_done;
  logic                 r_err;

  state_e               w_state_d;
  logic [DIV_W-1:0]     w_cnt_d;
  logic [DIV_W-1:0]     w_period_d;
  logic [SWEEP_W-1:0]   w_sweeps_d;
  logic [SWEEP_W-1:0]   w_sweep_cnt_d;
  logic                 w_shift_sel_d;
  logic                 w_shift_rst_d;
  logic                 w_done_d;
  logic                 w_err_d;

  logic                 w_busy;
  logic                 w_onehot;
  logic                 w_sweep_ev;
  logic                 w_pos_bad;
  logic [SWEEP_W-1:0]   w_sweep_inc;

  assign w_busy      = (r_state != StIdle);
  assign w_onehot    = (i_pos != 8'd0) && ((i_pos & (i_pos - 8'd1)) == 8'd0);
  // The shift now being applied moves the bit from 8'h02 into the LSB.
  assign w_sweep_ev  = r_shift_sel && (i_pos == 8'h02) && w_busy;
  // Ignore pos while the shifter is still being reloaded.
  assign w_pos_bad   = w_busy && !r_shift_rst && !w_onehot;
  assign w_sweep_inc = r_sweep_cnt + SWEEP_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_period    <= '0;
      r_sweeps    <= '0;
      r_sweep_cnt <= '0;
      r_shift_sel <= 1'b0;
      r_shift_rst <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_period    <= w_period_d;
      r_sweeps    <= w_sweeps_d;
      r_sweep_cnt <= w_sweep_cnt_d;
      r_shift_sel <= w_shift_sel_d;
      r_shift_rst <= w_shift_rst_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_period_d    = r_period;
    w_sweeps_d    = r_sweeps;
    w_sweep_cnt_d = r_sweep_cnt;
    w_shift_sel_d = 1'b0;
    w_shift_rst_d = 1'b0;
    w_done_d      = 1'b0;
    w_err_d       = r_err;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_period_d    = i_period;
          w_sweeps_d    = i_sweeps;
          w_sweep_cnt_d = '0;
          w_cnt_d       = '0;
          w_err_d       = 1'b0;
          w_shift_rst_d = 1'b1;
          w_state_d     = StRun;
        end
      end
      StRun: begin
        if (i_stop) begin
          w_state_d = StPaused;
        end else if (r_cnt == r_period) begin
          w_shift_sel_d = 1'b1;
          w_cnt_d       = '0;
        end else begin
          w_cnt_d = r_cnt + DIV_W'(1);
        end
      end
      StPaused: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (i_start) begin
          w_state_d = StRun;
        end else if (i_step) begin
          w_shift_sel_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_sweep_ev) begin
      w_sweep_cnt_d = w_sweep_inc;
      if ((r_sweeps != '0) && (w_sweep_inc == r_sweeps)) begin
        w_state_d     = StIdle;
        w_done_d      = 1'b1;
        w_shift_sel_d = 1'b0;
      end
    end

    if (w_pos_bad) begin
      w_err_d       = 1'b1;
      w_state_d     = StIdle;
      w_shift_sel_d = 1'b0;
      w_done_d      = 1'b0;
    end
  end

  assign o_shift_sel = r_shift_sel;
  assign o_shift_rst = r_shift_rst;
  assign o_busy      = w_busy;
  assign o_paused    = (r_state == StPaused);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_sweep_cnt = r_sweep_cnt;

endmodule
